// File: rtl/uart_tx_monitor.sv
`default_nettype none
// ==========================================================================
// uart_tx_monitor: samples the SoC UART TX line and checks parity/framing.
// Good bytes go into a FWFT FIFO with a valid/ready port.      Rev 1.0
// ==========================================================================
module uart_tx_monitor #(
  parameter int BAUD_DIV   = 868,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_AW    = 4
) (
  input  logic               SYSCLK,
  input  logic               SYSRESET,
  input  logic               SER_IN,
  output logic [7:0]         DATA_OUT,
  output logic               DATA_VALID,
  input  logic               DATA_READY,
  output logic [FIFO_AW:0]   FIFO_LEVEL,
  output logic [15:0]        BYTE_COUNT,
  output logic               FRAMING_ERR,
  output logic               PARITY_ERR,
  output logic               OVERFLOW,
  input  logic               CLEAR_ERR
);

  localparam int                  c_cnt_w = $clog2(BAUD_DIV);
  localparam int                  c_depth = 2 ** FIFO_AW;
  localparam logic [c_cnt_w-1:0]  c_half  = c_cnt_w'(BAUD_DIV / 2 - 1);
  localparam logic [c_cnt_w-1:0]  c_full  = c_cnt_w'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0]    c_lvl_full = (FIFO_AW + 1)'(c_depth);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, s_prev_q;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_flag_q, ferr_flag_d;
  logic                 perr_flag_q, perr_flag_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [15:0]          count_q, count_d;
  logic [7:0]           mem_q [c_depth];

  logic w_s, w_tick, w_push, w_ferr_set, w_perr_set;
  logic w_pop, w_full, w_acc, w_ovf_set;

  assign w_s    = sync2_q;
  assign w_tick = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    w_perr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_prev_q && !w_s) begin
          cnt_d   = c_half;
          perr_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!w_tick) cnt_d = cnt_q - 1'b1;
        else if (w_s) state_d = ST_IDLE;
        else begin
          cnt_d   = c_full;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!w_tick) cnt_d = cnt_q - 1'b1;
        else begin
          shift_d = {w_s, shift_q[7:1]};
          cnt_d   = c_full;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (!w_tick) cnt_d = cnt_q - 1'b1;
        else begin
          // Data ones plus the parity bit must be even (or odd) in total.
          perr_d  = ((^shift_q) ^ w_s) != (PARITY_ODD != 0);
          cnt_d   = c_full;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!w_tick) cnt_d = cnt_q - 1'b1;
        else if (!w_s) begin
          w_ferr_set = 1'b1;
          state_d    = ST_BREAK;
        end else begin
          w_perr_set = perr_q;
          w_push     = !perr_q;
          state_d    = ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (w_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_pop     = (level_q != '0) && DATA_READY;
  assign w_full    = (level_q == c_lvl_full);
  assign w_acc     = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_comb begin
    wr_ptr_d    = w_acc ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d    = w_pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d     = w_acc ? count_q + 16'd1 : count_q;
    level_d     = level_q;
    case ({w_acc, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // A new error in the same cycle as a clear leaves the flag set.
    ferr_flag_d = (ferr_flag_q & ~CLEAR_ERR) | w_ferr_set;
    perr_flag_d = (perr_flag_q & ~CLEAR_ERR) | w_perr_set;
    ovf_flag_d  = (ovf_flag_q  & ~CLEAR_ERR) | w_ovf_set;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      s_prev_q    <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      perr_q      <= 1'b0;
      ferr_flag_q <= 1'b0;
      perr_flag_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      count_q     <= 16'd0;
    end else begin
      sync1_q     <= SER_IN;
      sync2_q     <= sync1_q;
      s_prev_q    <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      ferr_flag_q <= ferr_flag_d;
      perr_flag_q <= perr_flag_d;
      ovf_flag_q  <= ovf_flag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (w_acc) mem_q[wr_ptr_q] <= shift_q;
  end

  assign DATA_VALID  = (level_q != '0);
  assign DATA_OUT    = DATA_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign FIFO_LEVEL  = level_q;
  assign BYTE_COUNT  = count_q;
  assign FRAMING_ERR = ferr_flag_q;
  assign PARITY_ERR  = perr_flag_q;
  assign OVERFLOW    = ovf_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_monitor.sv
`default_nettype none
// ==========================================================================
// tb_uart_tx_monitor: bench for uart_tx_monitor (8N1 and 8E1 instances)
// against a queue-based model of the received byte stream.     Rev 1.0
// ==========================================================================
module tb_uart_tx_monitor;

  localparam int BAUD = 16;
  localparam int AW   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ser = 1'b1, ready = 1'b0, clr = 1'b0;
  logic [7:0]    dout;
  logic          valid, ferr, perr, ovf;
  logic [AW:0]   level;
  logic [15:0]   bcnt;

  logic          ser_p = 1'b1, ready_p = 1'b0, clr_p = 1'b0;
  logic [7:0]    dout_p;
  logic          valid_p, ferr_p, perr_p, ovf_p;
  logic [AW:0]   level_p;
  logic [15:0]   bcnt_p;

  uart_tx_monitor #(.BAUD_DIV(BAUD), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_AW(AW)) dut (
    .SYSCLK(clk), .SYSRESET(rst), .SER_IN(ser), .DATA_OUT(dout), .DATA_VALID(valid),
    .DATA_READY(ready), .FIFO_LEVEL(level), .BYTE_COUNT(bcnt), .FRAMING_ERR(ferr),
    .PARITY_ERR(perr), .OVERFLOW(ovf), .CLEAR_ERR(clr));

  uart_tx_monitor #(.BAUD_DIV(BAUD), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_AW(AW)) dut_p (
    .SYSCLK(clk), .SYSRESET(rst), .SER_IN(ser_p), .DATA_OUT(dout_p), .DATA_VALID(valid_p),
    .DATA_READY(ready_p), .FIFO_LEVEL(level_p), .BYTE_COUNT(bcnt_p), .FRAMING_ERR(ferr_p),
    .PARITY_ERR(perr_p), .OVERFLOW(ovf_p), .CLEAR_ERR(clr_p));

  int tests = 0;
  int fails = 0;

  // Reference model for the 8N1 instance (only valid while nobody pops).
  logic [7:0] mq[$];
  int         m_cnt;
  logic       m_fe, m_pe, m_ov;

  int         pop_cnt;
  logic [7:0] last_pop;
  always @(negedge clk) begin
    if (valid && ready) begin
      pop_cnt  = pop_cnt + 1;
      last_pop = dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_good(input logic [7:0] b);
    if (mq.size() < DEPTH) begin
      mq.push_back(b);
      m_cnt = (m_cnt + 1) % 65536;
    end else m_ov = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    @(negedge clk);
    if (sel) ser_p = v; else ser = v;
    repeat (BAUD - 1) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop, input int gap);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, par);
    drive_bit(sel, stop);
    if (gap > 0) begin
      @(negedge clk);
      if (sel) ser_p = 1'b1; else ser = 1'b1;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".valid"}, 32'(valid), 32'(mq.size() != 0));
    chk({tag, ".count"}, 32'(bcnt), 32'(m_cnt));
    chk({tag, ".ferr"}, 32'(ferr), 32'(m_fe));
    chk({tag, ".perr"}, 32'(perr), 32'(m_pe));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ov));
    if (mq.size() != 0) chk({tag, ".head"}, 32'(dout), 32'(mq[0]));
  endtask

  task automatic drain(input string tag);
    while (mq.size() != 0) begin
      @(negedge clk);
      chk({tag, ".dvalid"}, 32'(valid), 32'd1);
      chk({tag, ".dout"}, 32'(dout), 32'(mq[0]));
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      void'(mq.pop_front());
    end
    @(negedge clk);
    chk({tag, ".empty"}, 32'(valid), 32'd0);
    chk({tag, ".lvl0"}, 32'(level), 32'd0);
  endtask

  task automatic clear_flags();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic pop_p();
    @(negedge clk); ready_p = 1'b1;
    @(negedge clk); ready_p = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit         bad;
    int         n;
    model_reset();
    pop_cnt = 0; last_pop = 8'h00;
    do_reset();

    // Reset values
    chk("rst.dout", 32'(dout), 32'h0);
    check_state("rst");

    // 0x55 with the consumer always ready
    ready = 1'b1;
    send_frame(0, 8'h55, 0, 1'b0, 1'b1, BAUD);
    ready = 1'b0;
    m_cnt = 1;
    chk("b55.pops", 32'(pop_cnt), 32'd1);
    chk("b55.data", 32'(last_pop), 32'h55);
    check_state("b55");

    // Short low glitch must be rejected, and the receiver must still work afterwards
    @(negedge clk); ser = 1'b0;
    repeat (6) @(negedge clk);
    ser = 1'b1;
    repeat (40) @(negedge clk);
    check_state("glitch");
    b = 8'($urandom);
    send_frame(0, b, 0, 1'b0, 1'b1, BAUD);
    model_good(b);
    check_state("postglitch");
    drain("postglitch");

    // Bad stop bit followed by a held-low line, then a good byte
    send_frame(0, 8'hA3, 0, 1'b0, 1'b0, 0);
    repeat (40) @(negedge clk);
    @(negedge clk); ser = 1'b1;
    repeat (BAUD) @(negedge clk);
    m_fe = 1'b1;
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, BAUD);
    model_good(8'h3C);
    check_state("break");
    drain("break");
    clear_flags();
    check_state("clr");

    // Overflow: five bytes into a four-entry FIFO with no consumer
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 0, 1'b0, 1'b1, BAUD);
      model_good(8'(i));
    end
    check_state("ovf");
    drain("ovf");
    clear_flags();

    // Randomised bursts with occasional bad stop bits
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b   = 8'($urandom);
        bad = ($urandom_range(0, 4) == 0);
        send_frame(0, b, 0, 1'b0, !bad, BAUD + $urandom_range(0, 20));
        if (bad) m_fe = 1'b1; else model_good(b);
      end
      check_state("rnd");
      drain("rnd");
      clear_flags();
      check_state("rndclr");
    end

    // Even parity instance
    send_frame(1, 8'h07, 1, 1'b1, 1'b1, BAUD);
    @(negedge clk);
    chk("par.level", 32'(level_p), 32'd1);
    chk("par.dout", 32'(dout_p), 32'h07);
    chk("par.perr", 32'(perr_p), 32'd0);
    pop_p();
    send_frame(1, 8'h07, 1, 1'b0, 1'b1, BAUD);
    @(negedge clk);
    chk("parbad.perr", 32'(perr_p), 32'd1);
    chk("parbad.level", 32'(level_p), 32'd0);
    chk("parbad.count", 32'(bcnt_p), 32'd1);
    chk("parbad.ferr", 32'(ferr_p), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); clr_p = 1'b1;
      @(negedge clk); clr_p = 1'b0;
      b   = 8'($urandom);
      bad = $urandom_range(0, 1);
      send_frame(1, b, 1, (($countones(b) % 2) == 1) ^ bad, 1'b1, BAUD);
      @(negedge clk);
      chk("prnd.perr", 32'(perr_p), 32'(bad));
      chk("prnd.level", 32'(level_p), 32'(!bad));
      if (!bad) begin
        chk("prnd.dout", 32'(dout_p), 32'(b));
        pop_p();
      end
    end

    // Reset in the middle of D3 of 0xFF, then 0x42
    @(negedge clk); ser = 1'b0;
    repeat (BAUD - 1) @(negedge clk);
    @(negedge clk); ser = 1'b1;
    repeat (3 * BAUD + BAUD / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (8 * BAUD) @(negedge clk);
    send_frame(0, 8'h42, 0, 1'b0, 1'b1, BAUD);
    model_good(8'h42);
    check_state("midrst");
    drain("midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
